fpadd_stage_buffer: RTL and testbench

//  Elastic pipeline register between FP-adder stages. Carries the aligned-operand bundle:
//   per-operand sign, exponent and mantissa, plus swap flag s.

---
 rtl/fpadd_pkg.sv | 49 ++++
 rtl/fpadd_skid_slot.sv | 42 ++++
 rtl/fpadd_stage_buffer.sv | 169 ++++++++++++++++
 tb/tb_fpadd_stage_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared definitions for the FP-adder stage buffers: default field widths, bundle
// packing offsets and the buffer occupancy state encoding.
package fpadd_pkg;

    localparam int DEF_EXP_W  = 8;
    localparam int DEF_MANT_W = 24;

    // Packed bundle layout, MSB to LSB: sign_a, exp_a, mant_a, sign_b, exp_b, mant_b, s
    localparam int BUNDLE_W = 2 * (1 + DEF_EXP_W + DEF_MANT_W) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    function automatic int bundle_w(input int exp_w, input int mant_w);
        return 2 * (1 + exp_w + mant_w) + 1;
    endfunction

    function automatic int off_s();
        return 0;
    endfunction

    function automatic int off_mant_b();
        return 1;
    endfunction

    function automatic int off_exp_b(input int mant_w);
        return 1 + mant_w;
    endfunction

    function automatic int off_sign_b(input int exp_w, input int mant_w);
        return 1 + mant_w + exp_w;
    endfunction

    function automatic int off_mant_a(input int exp_w, input int mant_w);
        return 2 + mant_w + exp_w;
    endfunction

    function automatic int off_exp_a(input int exp_w, input int mant_w);
        return 2 + 2 * mant_w + exp_w;
    endfunction

    function automatic int off_sign_a(input int exp_w, input int mant_w);
        return 2 + 2 * mant_w + 2 * exp_w;
    endfunction

endpackage

// File: rtl/fpadd_skid_slot.sv
// One bundle-wide storage slot: a valid bit plus a data register that only loads
// on a write enable. Clear has priority over load for the valid bit.
module fpadd_skid_slot
    import fpadd_pkg::*;
#(
    parameter int W = BUNDLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
        end
    end

    // Data is left untouched on clear; occupancy is carried by the valid bit alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (load && !clear) begin
            data_reg <= d;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule

// File: rtl/fpadd_stage_buffer.sv
// Elastic two-entry (main + skid) buffer for the aligned FP-adder operand bundle.
// Optional saturating stall counter is built when FPADD_BUF_STALL_CNT_EN is defined.
module fpadd_stage_buffer
    import fpadd_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W
`ifdef FPADD_BUF_STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign_a,
    input  logic              in_sign_b,
    input  logic [EXP_W-1:0]  in_exp_a,
    input  logic [EXP_W-1:0]  in_exp_b,
    input  logic [MANT_W-1:0] in_mant_a,
    input  logic [MANT_W-1:0] in_mant_b,
    input  logic              in_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign_a,
    output logic              out_sign_b,
    output logic [EXP_W-1:0]  out_exp_a,
    output logic [EXP_W-1:0]  out_exp_b,
    output logic [MANT_W-1:0] out_mant_a,
    output logic [MANT_W-1:0] out_mant_b,
    output logic              out_s
`ifdef FPADD_BUF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    localparam int BW         = bundle_w(EXP_W, MANT_W);
    localparam int OFF_S      = off_s();
    localparam int OFF_MANT_B = off_mant_b();
    localparam int OFF_EXP_B  = off_exp_b(MANT_W);
    localparam int OFF_SIGN_B = off_sign_b(EXP_W, MANT_W);
    localparam int OFF_MANT_A = off_mant_a(EXP_W, MANT_W);
    localparam int OFF_EXP_A  = off_exp_a(EXP_W, MANT_W);
    localparam int OFF_SIGN_A = off_sign_a(EXP_W, MANT_W);

    // Slot 0 is main (drives the outputs), slot 1 is skid.
    localparam int MAIN = 0;
    localparam int SKID = 1;

    buf_state_t     state_reg;
    buf_state_t     state_next;

    logic [1:0]     slot_load;
    logic [1:0]     slot_clr;
    logic [1:0]     slot_valid;
    logic [BW-1:0]  slot_d [2];
    logic [BW-1:0]  slot_q [2];

    logic [BW-1:0]  in_bundle;
    logic           accept;
    logic           retire;

    assign in_bundle = {in_sign_a, in_exp_a, in_mant_a, in_sign_b, in_exp_b, in_mant_b, in_s};

    // in_ready depends only on the skid valid register, never on out_ready.
    assign in_ready  = ~slot_valid[SKID];
    assign out_valid = slot_valid[MAIN];
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            fpadd_skid_slot #(
                .W (BW)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .load  (slot_load[gi]),
                .clear (slot_clr[gi]),
                .d     (slot_d[gi]),
                .valid (slot_valid[gi]),
                .q     (slot_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        slot_load      = 2'b00;
        slot_clr       = 2'b00;
        slot_d[MAIN]   = in_bundle;
        slot_d[SKID]   = in_bundle;

        if (flush) begin
            // Flush overrides any same-cycle accept or retire.
            slot_clr   = 2'b11;
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        slot_load[MAIN] = 1'b1;
                        state_next      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        slot_load[MAIN] = 1'b1;
                    end else if (accept) begin
                        slot_load[SKID] = 1'b1;
                        state_next      = ST_FULL;
                    end else if (retire) begin
                        slot_clr[MAIN]  = 1'b1;
                        state_next      = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (retire) begin
                        slot_d[MAIN]    = slot_q[SKID];
                        slot_load[MAIN] = 1'b1;
                        slot_clr[SKID]  = 1'b1;
                        state_next      = ST_ONE;
                    end
                end
                default: begin
                    slot_clr   = 2'b11;
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    assign out_s      = slot_q[MAIN][OFF_S];
    assign out_mant_b = slot_q[MAIN][OFF_MANT_B +: MANT_W];
    assign out_exp_b  = slot_q[MAIN][OFF_EXP_B +: EXP_W];
    assign out_sign_b = slot_q[MAIN][OFF_SIGN_B];
    assign out_mant_a = slot_q[MAIN][OFF_MANT_A +: MANT_W];
    assign out_exp_a  = slot_q[MAIN][OFF_EXP_A +: EXP_W];
    assign out_sign_a = slot_q[MAIN][OFF_SIGN_A];

`ifdef FPADD_BUF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_reg <= '0;
        end else if (flush) begin
            stall_count_reg <= '0;
        end else if (in_valid && !in_ready && (stall_count_reg != {CNT_W{1'b1}})) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_fpadd_stage_buffer.sv
// Self-checking bench for fpadd_stage_buffer: vector table, directed corner sequences
// and a queue scoreboard that follows every accept/retire.
module tb_fpadd_stage_buffer;

    typedef struct packed {
        logic        sign_a;
        logic [7:0]  exp_a;
        logic [23:0] mant_a;
        logic        sign_b;
        logic [7:0]  exp_b;
        logic [23:0] mant_b;
        logic        s;
    } bundle_t;

    typedef struct {
        logic in_valid;
        logic out_ready;
        int   exp_a;
        logic exp_out_valid;
        logic exp_in_ready;
        int   exp_out_exp_a;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    bundle_t     in_b = '0;
    bundle_t     out_b;
    logic        out_sign_a, out_sign_b, out_s;
    logic [7:0]  out_exp_a, out_exp_b;
    logic [23:0] out_mant_a, out_mant_b;
`ifdef FPADD_BUF_STALL_CNT_EN
    logic [3:0]  stall_count;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bundle_t sb_q[$];

    always #5 clk = ~clk;

    fpadd_stage_buffer #(
        .EXP_W  (8),
        .MANT_W (24)
`ifdef FPADD_BUF_STALL_CNT_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign_a  (in_b.sign_a),
        .in_sign_b  (in_b.sign_b),
        .in_exp_a   (in_b.exp_a),
        .in_exp_b   (in_b.exp_b),
        .in_mant_a  (in_b.mant_a),
        .in_mant_b  (in_b.mant_b),
        .in_s       (in_b.s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sign_a (out_sign_a),
        .out_sign_b (out_sign_b),
        .out_exp_a  (out_exp_a),
        .out_exp_b  (out_exp_b),
        .out_mant_a (out_mant_a),
        .out_mant_b (out_mant_b),
        .out_s      (out_s)
`ifdef FPADD_BUF_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    assign out_b = {out_sign_a, out_exp_a, out_mant_a, out_sign_b, out_exp_b, out_mant_b, out_s};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h t=%0t", name, act, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bundle_t mk(input int i);
        bundle_t b;
        b.sign_a = i[0];
        b.exp_a  = i[7:0];
        b.mant_a = 24'h800000 | (i * 3);
        b.sign_b = i[1];
        b.exp_b  = 8'(i + 3);
        b.mant_b = 24'(i * 5) ^ 24'h5A5A5A;
        b.s      = i[2];
        return b;
    endfunction

    task automatic fill_full(input bundle_t a, input bundle_t b);
        out_ready = 1'b0;
        in_b = a; in_valid = 1'b1;
        step();
        in_b = b;
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: occupancy check, then pop on retire and push on accept for the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb_q.delete();
            end else begin
                checks++;
                if (out_valid !== (sb_q.size() != 0)) begin
                    errors++;
                    $display("FAIL occ_out_valid actual=%b required=%b t=%0t", out_valid, sb_q.size() != 0, $time);
                end
                checks++;
                if (in_ready !== (sb_q.size() < 2)) begin
                    errors++;
                    $display("FAIL occ_in_ready actual=%b required=%b t=%0t", in_ready, sb_q.size() < 2, $time);
                end
                if (flush) begin
                    sb_q.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL sb_unexpected actual=%h required=none t=%0t", out_b, $time);
                        end else begin
                            bundle_t e;
                            e = sb_q.pop_front();
                            if (out_b !== e) begin
                                errors++;
                                $display("FAIL sb_data actual=%h required=%h t=%0t", out_b, e, $time);
                            end else begin
                                $display("ok   sb_retire %h t=%0t", out_b, $time);
                            end
                        end
                    end
                    if (in_valid && in_ready) sb_q.push_back(in_b);
                end
            end
        end
    end

    vec_t tbl[10];
    bundle_t ba, bb, bc;

    initial begin
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b1, i + 1, 1'b1, 1'b1, i + 1};
        tbl[8] = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 0};
        tbl[9] = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 0};

        // Reset values
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_exp_a", out_exp_a, 8'h00);
        chk("rst_out_mant_a", out_mant_a, 24'h0);
`ifdef FPADD_BUF_STALL_CNT_EN
        chk("rst_stall_count", stall_count, 4'h0);
`endif

        // Streaming through ONE with simultaneous accept+retire
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].in_valid;
            out_ready = tbl[i].out_ready;
            in_b = mk(tbl[i].exp_a);
            step();
            chk($sformatf("stream%0d_out_valid", i), out_valid, tbl[i].exp_out_valid);
            chk($sformatf("stream%0d_in_ready", i), in_ready, tbl[i].exp_in_ready);
            if (tbl[i].exp_out_valid) chk($sformatf("stream%0d_exp_a", i), out_exp_a, 8'(tbl[i].exp_out_exp_a));
        end

        // Backpressure: A then B, hold, then drain in order
        ba = mk(20); ba.exp_a = 8'h7F; ba.mant_a = 24'h800000;
        bb = mk(21);
        out_ready = 1'b0;
        in_b = ba; in_valid = 1'b1;
        step();
        chk("bp_one_in_ready", in_ready, 1'b1);
        chk("bp_one_exp_a", out_exp_a, 8'h7F);
        in_b = bb;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_full_in_ready", in_ready, 1'b0);
            chk("bp_full_hold", out_b, ba);
        end
        out_ready = 1'b1;
        step();
        chk("bp_after_a", out_b, bb);
        chk("bp_after_a_in_ready", in_ready, 1'b1);
        step();
        chk("bp_after_b_out_valid", out_valid, 1'b0);

        // Flush while FULL with a bundle presented
        fill_full(mk(30), mk(31));
        bc = mk(32);
        in_b = bc; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_pre_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        step();
        chk("flush_dropped", out_valid, 1'b0);

        // Flush in EMPTY wins over a same-cycle accept
        in_b = mk(33); in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_vs_accept", out_valid, 1'b0);

        // Async reset mid-FULL
        fill_full(mk(40), mk(41));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_exp_a", out_exp_a, 8'h00);
        step();
        rst = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("arst_no_bundle", out_valid, 1'b0);

`ifdef FPADD_BUF_STALL_CNT_EN
        // Stall counter saturation and flush clear
        fill_full(mk(50), mk(51));
        in_b = mk(52); in_valid = 1'b1;
        step(); step(); step();
        chk("stall_count_3", stall_count, 4'h3);
        for (int i = 0; i < 17; i++) step();
        chk("stall_count_sat", stall_count, 4'hF);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("stall_count_flush", stall_count, 4'h0);
`endif

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            in_b = bundle_t'({$urandom, $urandom, $urandom});
            in_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush = ($urandom_range(39) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("drain_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
